// File: rtl/fsm_out_pkg.sv
// Shared types and constants for the controller output-word decoder.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//
// Holds the decoder state enum, alarm cause encodings, symbol codes and the
// 17 legal 20-bit controller output words. Bit k-1 of a word carries y(k).
package fsm_out_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_SILENT = 2'd2,
        ST_ALARM  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_SILENCE = 2'b01;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b10;

    localparam logic [4:0] SYM_IDLE    = 5'd0;
    localparam logic [4:0] SYM_01      = 5'd1;   // {y16}
    localparam logic [4:0] SYM_02      = 5'd2;   // {y19}
    localparam logic [4:0] SYM_03      = 5'd3;   // {y1,y8,y9}
    localparam logic [4:0] SYM_04      = 5'd4;   // {y1,y2,y3}
    localparam logic [4:0] SYM_05      = 5'd5;   // {y1,y2,y12}
    localparam logic [4:0] SYM_06      = 5'd6;   // {y2,y10,y12}
    localparam logic [4:0] SYM_07      = 5'd7;   // {y18}
    localparam logic [4:0] SYM_08      = 5'd8;   // {y10,y11,y12}
    localparam logic [4:0] SYM_09      = 5'd9;   // {y7,y9,y15}
    localparam logic [4:0] SYM_10      = 5'd10;  // {y5}
    localparam logic [4:0] SYM_11      = 5'd11;  // {y4}
    localparam logic [4:0] SYM_12      = 5'd12;  // {y8,y9,y17}
    localparam logic [4:0] SYM_13      = 5'd13;  // {y6}
    localparam logic [4:0] SYM_14      = 5'd14;  // {y1,y11,y12}
    localparam logic [4:0] SYM_15      = 5'd15;  // {y20}
    localparam logic [4:0] SYM_16      = 5'd16;  // {y1,y9,y14,y15}
    localparam logic [4:0] SYM_17      = 5'd17;  // {y13}
    localparam logic [4:0] SYM_ILLEGAL = 5'd31;

    localparam logic [19:0] WORD_IDLE = 20'h00000;
    localparam logic [19:0] WORD_01   = 20'h08000;
    localparam logic [19:0] WORD_02   = 20'h40000;
    localparam logic [19:0] WORD_03   = 20'h00181;
    localparam logic [19:0] WORD_04   = 20'h00007;
    localparam logic [19:0] WORD_05   = 20'h00803;
    localparam logic [19:0] WORD_06   = 20'h00A02;
    localparam logic [19:0] WORD_07   = 20'h20000;
    localparam logic [19:0] WORD_08   = 20'h00E00;
    localparam logic [19:0] WORD_09   = 20'h04140;
    localparam logic [19:0] WORD_10   = 20'h00010;
    localparam logic [19:0] WORD_11   = 20'h00008;
    localparam logic [19:0] WORD_12   = 20'h10180;
    localparam logic [19:0] WORD_13   = 20'h00020;
    localparam logic [19:0] WORD_14   = 20'h00C01;
    localparam logic [19:0] WORD_15   = 20'h80000;
    localparam logic [19:0] WORD_16   = 20'h06101;
    localparam logic [19:0] WORD_17   = 20'h01000;

endpackage

// File: rtl/fsm_out_sym_lut.sv
// Purpose: exact-match lookup of a 20-bit controller output word to a symbol code.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the input word.
//
// Ports:
//   y    - controller output word, y[k-1] = y(k)
//   code - symbol code 0..17, or 31 for any word outside the alphabet
module fsm_out_sym_lut
    import fsm_out_pkg::*;
(
    input  logic [19:0] y,
    output logic [4:0]  code
);

    always_comb begin
        code = SYM_ILLEGAL;
        case (y)
            WORD_IDLE: code = SYM_IDLE;
            WORD_01:   code = SYM_01;
            WORD_02:   code = SYM_02;
            WORD_03:   code = SYM_03;
            WORD_04:   code = SYM_04;
            WORD_05:   code = SYM_05;
            WORD_06:   code = SYM_06;
            WORD_07:   code = SYM_07;
            WORD_08:   code = SYM_08;
            WORD_09:   code = SYM_09;
            WORD_10:   code = SYM_10;
            WORD_11:   code = SYM_11;
            WORD_12:   code = SYM_12;
            WORD_13:   code = SYM_13;
            WORD_14:   code = SYM_14;
            WORD_15:   code = SYM_15;
            WORD_16:   code = SYM_16;
            WORD_17:   code = SYM_17;
            default:   code = SYM_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/fsm_out_decoder.sv
// Purpose: decode controller output words to symbols; flag silence runs and illegal words.
// Latency: 1 cycle from sampled word to sym_code/sym_valid and alarm.
// Backpressure: none; one word accepted every cycle.
//
// Ports:
//   clk, rst_n            - clock and synchronous active-low reset
//   y_in, y_valid         - controller output word and its sample strobe
//   alarm_clr             - returns to IDLE, clears alarm and both counters
//   sym_code, sym_valid   - last decoded symbol and one-cycle update pulse
//   alarm, alarm_cause    - sticky flag and first cause (01 silence, 10 illegal)
//   silent_run            - consecutive zero-word count, saturating at 255
//   illegal_cnt           - illegal words seen, saturating at 255
//   hist                  - symbol history, newest in LSBs (FSM_OUT_HIST_EN only)
//
// Optional feature macro: FSM_OUT_HIST_EN adds the HIST_DEPTH-entry history.
module fsm_out_decoder
    import fsm_out_pkg::*;
#(
    parameter int SILENT_MAX = 8,
    parameter int HIST_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] y_in,
    input  logic        y_valid,
    input  logic        alarm_clr,
    output logic [4:0]  sym_code,
    output logic        sym_valid,
    output logic        alarm,
    output logic [1:0]  alarm_cause,
    output logic [7:0]  silent_run,
    output logic [7:0]  illegal_cnt
`ifdef FSM_OUT_HIST_EN
    ,
    output logic [5*HIST_DEPTH-1:0] hist
`endif
);

    localparam logic [7:0] SILENT_LIMIT = 8'(SILENT_MAX);

    state_t     state;
    logic [4:0] lut_code;
    logic       is_zero;
    logic       is_illegal;
    logic [7:0] run_inc;
    logic [7:0] ill_inc;

    fsm_out_sym_lut u_lut (
        .y    (y_in),
        .code (lut_code)
    );

    assign is_zero    = (y_in == WORD_IDLE);
    assign is_illegal = (lut_code == SYM_ILLEGAL);
    assign run_inc    = (silent_run == 8'hFF) ? 8'hFF : silent_run + 8'd1;
    assign ill_inc    = (illegal_cnt == 8'hFF) ? 8'hFF : illegal_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            sym_code    <= SYM_IDLE;
            sym_valid   <= 1'b0;
            alarm       <= 1'b0;
            alarm_cause <= CAUSE_NONE;
            silent_run  <= 8'd0;
            illegal_cnt <= 8'd0;
        end else begin
            // Decoding is independent of state and of alarm_clr.
            sym_valid <= y_valid;
            if (y_valid) begin
                sym_code <= lut_code;
            end

            if (alarm_clr) begin
                // Clear beats any word sampled in the same cycle.
                state       <= ST_IDLE;
                alarm       <= 1'b0;
                alarm_cause <= CAUSE_NONE;
                silent_run  <= 8'd0;
                illegal_cnt <= 8'd0;
            end else if (y_valid) begin
                if (is_illegal) begin
                    illegal_cnt <= ill_inc;
                end
                case (state)
                    ST_IDLE, ST_ACTIVE: begin
                        if (is_illegal) begin
                            state       <= ST_ALARM;
                            alarm       <= 1'b1;
                            alarm_cause <= CAUSE_ILLEGAL;
                            silent_run  <= 8'd0;
                        end else if (is_zero) begin
                            state      <= ST_SILENT;
                            silent_run <= 8'd1;
                        end else begin
                            state      <= ST_ACTIVE;
                            silent_run <= 8'd0;
                        end
                    end
                    ST_SILENT: begin
                        if (is_illegal) begin
                            state       <= ST_ALARM;
                            alarm       <= 1'b1;
                            alarm_cause <= CAUSE_ILLEGAL;
                            silent_run  <= 8'd0;
                        end else if (is_zero) begin
                            silent_run <= run_inc;
                            if (run_inc == SILENT_LIMIT) begin
                                state       <= ST_ALARM;
                                alarm       <= 1'b1;
                                alarm_cause <= CAUSE_SILENCE;
                            end
                        end else begin
                            state      <= ST_ACTIVE;
                            silent_run <= 8'd0;
                        end
                    end
                    ST_ALARM: begin
                        // State and cause frozen; the run keeps tracking the
                        // input so the harness can still see silence length.
                        if (is_zero) begin
                            silent_run <= run_inc;
                        end else begin
                            silent_run <= 8'd0;
                        end
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef FSM_OUT_HIST_EN
    // History shifts on every valid word, including during ALARM and clear;
    // only reset zeroes it.
    if (HIST_DEPTH > 1) begin : g_hist_multi
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hist <= '0;
            end else if (y_valid) begin
                hist <= {hist[5*HIST_DEPTH-6:0], lut_code};
            end
        end
    end else begin : g_hist_single
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                hist <= '0;
            end else if (y_valid) begin
                hist <= lut_code;
            end
        end
    end
`endif

endmodule
